td4_prog_mem: RTL and testbench

//  Program memory and loader serving td4_core's fetch interface: returns op
//  for the core's ip the same cycle, as combinational ROM-style read.

---
 rtl/td4_prog_mem_if.sv | 34 +++
 rtl/td4_prog_mem.sv | 79 +++++++
 tb/tb_td4_prog_mem.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/td4_prog_mem_if.sv
// Fetch and loader bundle between host, td4_prog_mem and td4_core.
// csum exists only when CHECKSUM_EN is defined.
interface td4_prog_mem_if #(
    parameter int AW = 4
);
    logic [AW-1:0] ip;
    logic [7:0]    op;
    logic          ld_start;
    logic          ld_valid;
    logic [7:0]    ld_data;
    logic          ld_ready;
    logic          ld_done;
    logic          busy;
    logic          core_rst_n;
`ifdef CHECKSUM_EN
    logic [7:0]    csum;
`endif

    modport master (
        output ip, ld_start, ld_valid, ld_data,
`ifdef CHECKSUM_EN
        input  csum,
`endif
        input  op, ld_ready, ld_done, busy, core_rst_n
    );

    modport slave (
        input  ip, ld_start, ld_valid, ld_data,
`ifdef CHECKSUM_EN
        output csum,
`endif
        output op, ld_ready, ld_done, busy, core_rst_n
    );
endinterface

// File: rtl/td4_prog_mem.sv
// TD4 program memory with combinational fetch and a byte-stream loader that
// holds the core in reset while reloading. CHECKSUM_EN adds a load checksum.
module td4_prog_mem #(
    parameter int AW       = 4,
    parameter int LOAD_LEN = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    td4_prog_mem_if.slave bus
);
    localparam int          DEPTH = 1 << AW;
    localparam logic [AW:0] LAST  = (AW+1)'(LOAD_LEN - 1);

    typedef enum logic [1:0] {RUN, LOAD, DONE} state_t;

    state_t      state_q, state_d;
    logic [AW:0] cnt_q;
    logic        run_q;
    logic        wr_en;
    logic [7:0]  mem_q [DEPTH];

    assign wr_en = (state_q == LOAD) && bus.ld_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.ld_start) state_d = LOAD;
            LOAD:    if (wr_en && cnt_q == LAST) state_d = DONE;
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            run_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            case (state_q)
                RUN: if (bus.ld_start) begin
                    cnt_q <= '0;
                    run_q <= 1'b0;
                end
                LOAD: if (wr_en && cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
                DONE: run_q <= 1'b1;
                default: ;
            endcase
        end
    end

    // Reset clears every word so an aborted load never leaves a partial program.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[cnt_q[AW-1:0]] <= bus.ld_data;
        end
    end

    assign bus.op         = mem_q[bus.ip];
    assign bus.ld_ready   = (state_q == LOAD);
    assign bus.ld_done    = (state_q == DONE);
    assign bus.busy       = (state_q != RUN);
    assign bus.core_rst_n = rst_n & run_q;

`ifdef CHECKSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               csum_q <= '0;
        else if (state_q == RUN && bus.ld_start)  csum_q <= '0;
        else if (wr_en)                           csum_q <= csum_q + bus.ld_data;
    end

    assign bus.csum = csum_q;
`endif
endmodule

// File: tb/tb_td4_prog_mem.sv
// Randomized bench for td4_prog_mem: two instances (LOAD_LEN 16 and 4) against
// a behavioural model, plus literal checks of the directed scenarios.
`timescale 1ns/1ps
module tb_td4_prog_mem;
    typedef logic [7:0] byte_q_t [$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       ld_start [2];
    logic       ld_valid [2];
    logic [7:0] ld_data  [2];
    logic [3:0] ip       [2];
    logic [7:0] op_o     [2];
    logic       rdy_o    [2];
    logic       done_o   [2];
    logic       busy_o   [2];
    logic       core_o   [2];
`ifdef CHECKSUM_EN
    logic [7:0] csum_o   [2];
`endif

    td4_prog_mem_if #(.AW(4)) bus0 ();
    td4_prog_mem_if #(.AW(4)) bus1 ();

    assign bus0.ip = ip[0];  assign bus0.ld_start = ld_start[0];
    assign bus0.ld_valid = ld_valid[0];  assign bus0.ld_data = ld_data[0];
    assign bus1.ip = ip[1];  assign bus1.ld_start = ld_start[1];
    assign bus1.ld_valid = ld_valid[1];  assign bus1.ld_data = ld_data[1];
    assign op_o[0] = bus0.op;  assign rdy_o[0] = bus0.ld_ready;  assign done_o[0] = bus0.ld_done;
    assign busy_o[0] = bus0.busy;  assign core_o[0] = bus0.core_rst_n;
    assign op_o[1] = bus1.op;  assign rdy_o[1] = bus1.ld_ready;  assign done_o[1] = bus1.ld_done;
    assign busy_o[1] = bus1.busy;  assign core_o[1] = bus1.core_rst_n;
`ifdef CHECKSUM_EN
    assign csum_o[0] = bus0.csum;  assign csum_o[1] = bus1.csum;
`endif

    td4_prog_mem #(.AW(4), .LOAD_LEN(16)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    td4_prog_mem #(.AW(4), .LOAD_LEN(4))  u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int ncmp = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: memory image, "loading" flag with byte count, one-cycle done flag.
    int         lens [2] = '{16, 4};
    logic [7:0] mm   [2][16];
    bit         ldg  [2];
    bit         dn   [2];
    int         n    [2];
    logic [7:0] cs   [2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                for (int j = 0; j < 16; j++) mm[k][j] = 8'h00;
                ldg[k] = 0; dn[k] = 0; n[k] = 0; cs[k] = 8'h00;
            end else if (dn[k]) begin
                dn[k] = 0;
            end else if (ldg[k]) begin
                if (ld_valid[k]) begin
                    mm[k][n[k]] = ld_data[k];
                    cs[k] = cs[k] + ld_data[k];
                    n[k]++;
                    if (n[k] == lens[k]) begin ldg[k] = 0; dn[k] = 1; end
                end
            end else if (ld_start[k]) begin
                ldg[k] = 1; n[k] = 0; cs[k] = 8'h00;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("op%0d", k),    op_o[k],   mm[k][ip[k]]);
            chk($sformatf("ready%0d", k), rdy_o[k],  ldg[k]);
            chk($sformatf("done%0d", k),  done_o[k], dn[k]);
            chk($sformatf("busy%0d", k),  busy_o[k], ldg[k] | dn[k]);
            chk($sformatf("core%0d", k),  core_o[k], rst_n & ~(ldg[k] | dn[k]));
`ifdef CHECKSUM_EN
            chk($sformatf("csum%0d", k),  csum_o[k], cs[k]);
`endif
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // mode 0: back-to-back, 1: valid toggles, 2: random gaps and ld_start noise
    task automatic do_load(input int k, input byte_q_t b, input int mode, input bit hold,
                           output int rdy_seen);
        int i = 0;
        int g = 0;
        rdy_seen = 0;
        ld_start[k] = 1'b1; tick(); ld_start[k] = 1'b0;
        while (i < b.size() && g < 200) begin
            ld_valid[k] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(g % 2 == 0) : 1'($urandom % 2);
            ld_data[k]  = ld_valid[k] ? b[i] : 8'($urandom);
            if (mode == 2) ld_start[k] = 1'($urandom % 2);
            if (rdy_o[k]) rdy_seen++;
            chk("core_rst_in_load", core_o[k], 0);
            if (ld_valid[k]) i++;
            tick(); g++;
        end
        chk("load_bytes_within_bound", i, b.size());
        ld_valid[k] = 1'b0; ld_start[k] = hold;
        chk("ld_done_after_last", done_o[k], 1);
        chk("core_rst_in_done", core_o[k], 0);
        chk("ready_in_done", rdy_o[k], 0);
        tick();
    endtask

    task automatic sweep(input int k, input byte_q_t exp, input string nm);
        for (int i = 0; i < 16; i++) begin
            ip[k] = 4'(i); #1;
            chk(nm, op_o[k], exp[i]);
            tick();
        end
    endtask

    initial begin
        byte_q_t pat, zeros, p4, exp4;
        int rs;
        for (int k = 0; k < 2; k++) begin
            ld_start[k] = 0; ld_valid[k] = 0; ld_data[k] = 0; ip[k] = 0;
        end
        for (int i = 0; i < 16; i++) begin
            pat.push_back(i == 0 ? 8'hB3 : 8'(i));
            zeros.push_back(8'h00);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // reset state
        for (int k = 0; k < 2; k++) begin
            chk("reset_core_rst_n", core_o[k], 1);
            chk("reset_busy", busy_o[k], 0);
            chk("reset_ready", rdy_o[k], 0);
        end
        sweep(0, zeros, "reset_op0");
        sweep(1, zeros, "reset_op1");

        // back-to-back 16-byte load
        do_load(0, pat, 0, 0, rs);
        chk("ready_cycles", rs, 16);
        ip[0] = 4'd0; #1;
        chk("op_ip0_after_load", op_o[0], 8'hB3);
        chk("core_released", core_o[0], 1);
        tick();

        // toggled valid, ld_start held through DONE into first RUN cycle
        do_load(0, pat, 1, 1, rs);
        chk("start_in_done_ignored", busy_o[0], 0);
        do_load(0, pat, 2, 0, rs);
        sweep(0, pat, "gapped_contents");

        // short load over earlier contents
        p4 = '{8'hB3, 8'h01, 8'h02, 8'h03};
        do_load(1, p4, 0, 0, rs);
        p4 = '{8'h31, 8'h51, 8'h90, 8'hF0};
        do_load(1, p4, 0, 0, rs);
        exp4 = zeros;
        exp4[0] = 8'h31; exp4[1] = 8'h51; exp4[2] = 8'h90; exp4[3] = 8'hF0;
        sweep(1, exp4, "short_load");

`ifdef CHECKSUM_EN
        p4 = '{8'hFF, 8'h02, 8'h00, 8'h00};
        do_load(1, p4, 0, 0, rs);
        chk("csum_after_done", csum_o[1], 8'h01);
        tick();
        chk("csum_holds", csum_o[1], 8'h01);
        ld_start[1] = 1'b1; tick(); ld_start[1] = 1'b0;
        chk("csum_cleared_on_start", csum_o[1], 8'h00);
        for (int i = 0; i < 4; i++) begin ld_valid[1] = 1'b1; ld_data[1] = 8'h10; tick(); end
        ld_valid[1] = 1'b0;
        tick();
        chk("csum_second_load", csum_o[1], 8'h40);
`endif

        // reset part-way through a load
        ld_start[0] = 1'b1; tick(); ld_start[0] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ld_valid[0] = 1'b1; ld_data[0] = 8'($urandom); ld_start[0] = 1'($urandom % 2);
            tick();
        end
        ld_valid[0] = 1'b0; ld_start[0] = 1'b0;
        chk("ready_before_abort", rdy_o[0], 1);
        rst_n = 1'b0; #1;
        chk("abort_core_rst", core_o[0], 0);
        chk("abort_busy", busy_o[0], 0);
        chk("abort_ready", rdy_o[0], 0);
        tick(); rst_n = 1'b1; tick();
        for (int i = 0; i < 20; i++) begin
            ld_valid[0] = 1'b1; ld_data[0] = 8'($urandom);
            chk("no_done_after_abort", done_o[0], 0);
            chk("valid_in_run_ignored", busy_o[0], 0);
            tick();
        end
        ld_valid[0] = 1'b0;
        sweep(0, zeros, "abort_cleared");

        // random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                ld_start[k] = 1'($urandom % 8 == 0);
                ld_valid[k] = 1'($urandom % 2);
                ld_data[k]  = 8'($urandom);
                ip[k]       = 4'($urandom);
            end
            if ($urandom % 400 == 0) begin
                rst_n = 1'b0; tick(); rst_n = 1'b1;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
